pcie_interrupt_sender: RTL

PCIE_INTERRUPT_SENDER -- requirements
Module: pcie_interrupt_sender

---
 rtl/pcie_interrupt_sender.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pcie_interrupt_sender.sv
// ---------------------------------------------------------------------------
// pcie_interrupt_sender
//
// Converts level interrupt requests from the rx and tx paths into MSI
// requests towards the PCIe endpoint core, then paces further MSIs.
//
// After the core grants an MSI, the block waits for the host to acknowledge
// it. Once acknowledged, it keeps a minimum idle gap before the next MSI. If
// no acknowledge arrives in time, the block goes back to IDLE, and a request
// that is still asserted sends the MSI again.
//
// Parameters
//   HOLDOFF_CYCLES  idle gap (clk cycles) after a host acknowledge
//   ACK_TIMEOUT     clk cycles to wait for a host acknowledge
//
// Ports
//   clk                  clock, rising edge
//   reset                synchronous, active-high reset
//   rx_send_interrupt    level request from the rx interrupt generator
//   tx_send_interrupt    level request from the tx completion path
//   interrupts_enabled   MSI enable from the core configuration space
//   interrupt_ack        one-cycle pulse on host interrupt-acknowledge write
//   cfg_interrupt_n      active-low MSI request to the endpoint core
//   cfg_interrupt_rdy_n  active-low grant from the endpoint core
//   cfg_interrupt_di     MSI cause vector {6'b0, tx, rx}
//   irq_count            number of MSIs granted by the core (wraps)
// ---------------------------------------------------------------------------
module pcie_interrupt_sender #(
    parameter logic [31:0] HOLDOFF_CYCLES = 32'd2500,
    parameter logic [31:0] ACK_TIMEOUT    = 32'd250000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_send_interrupt,
    input  logic        tx_send_interrupt,
    input  logic        interrupts_enabled,
    input  logic        interrupt_ack,
    output logic        cfg_interrupt_n,
    input  logic        cfg_interrupt_rdy_n,
    output logic [7:0]  cfg_interrupt_di,
    output logic [31:0] irq_count
);

    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        REQ      = 4'b0010,
        WAIT_ACK = 4'b0100,
        HOLDOFF  = 4'b1000
    } state_t;

    state_t      state_q, state_d;
    logic        int_n_q, int_n_d;
    logic [7:0]  di_q, di_d;
    logic [31:0] irq_count_q, irq_count_d;
    logic [31:0] counter_q, counter_d;

    always_comb begin
        state_d     = state_q;
        int_n_d     = int_n_q;
        di_d        = di_q;
        irq_count_d = irq_count_q;
        counter_d   = counter_q;

        case (state_q)
            IDLE: begin
                // Requests are levels.  They are sampled only here, and
                // only while MSIs are enabled. Nothing is latched.
                if (interrupts_enabled && (rx_send_interrupt || tx_send_interrupt)) begin
                    di_d    = {6'b0, tx_send_interrupt, rx_send_interrupt};
                    int_n_d = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // Hold the request and the cause vector steady until the core grants.
                if (!cfg_interrupt_rdy_n) begin
                    int_n_d     = 1'b1;
                    irq_count_d = irq_count_q + 32'd1;
                    counter_d   = ACK_TIMEOUT;
                    state_d     = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // An ack that arrives with an expired timeout still wins.
                if (interrupt_ack) begin
                    counter_d = HOLDOFF_CYCLES;
                    state_d   = HOLDOFF;
                end else if (counter_q == 32'd0) begin
                    state_d = IDLE;
                end else begin
                    counter_d = counter_q - 32'd1;
                end
            end
            HOLDOFF: begin
                // The block stays in HOLDOFF while the counter reads HOLDOFF_CYCLES..0.
                // That is HOLDOFF_CYCLES+1 cycles in total.
                if (counter_q == 32'd0) begin
                    state_d = IDLE;
                end else begin
                    counter_d = counter_q - 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
                int_n_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            int_n_q     <= 1'b1;
            di_q        <= 8'h00;
            irq_count_q <= 32'd0;
            counter_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            int_n_q     <= int_n_d;
            di_q        <= di_d;
            irq_count_q <= irq_count_d;
            counter_q   <= counter_d;
        end
    end

    assign cfg_interrupt_n  = int_n_q;
    assign cfg_interrupt_di = di_q;
    assign irq_count        = irq_count_q;

endmodule
